// File: rtl/demux16_stream.sv
// Registered 1-to-16 stream demultiplexer. Each input beat is routed by in_sel
// into a one-entry holding register on one of 16 independently handshaked outputs.
module demux16_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_sel,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic [15:0]              out_valid,
    input  logic [15:0]              out_ready,
    output logic [16*DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]     xfer_cnt
);

    localparam int NCH = 16;

    logic [NCH-1:0]                 valid_q, valid_d;
    logic [NCH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;

    logic [NCH-1:0] drain;
    logic           accept;

    // A full slot can still take a beat when its consumer empties it this same
    // edge; gating with rst_n keeps upstream from handing over a beat during reset.
    assign in_ready = rst_n && (!valid_q[in_sel] || out_ready[in_sel]);
    assign accept   = in_valid && in_ready;
    assign drain    = valid_q & out_ready;

    // NOTE: every always_comb output is given its default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q & ~drain;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (accept) begin
            // A load wins over a same-cycle drain of the same channel.
            valid_d[in_sel] = 1'b1;
            data_d[in_sel]  = in_data;
            cnt_d           = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    // NOTE: the data slots are reset along with the valid bits so that all
    // outputs read zero while rst_n is low, even though a slot is only meaningful
    // when its valid bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux16_stream.sv
// Directed self-checking bench for demux16_stream: routing, backpressure,
// same-cycle drain/refill, multi-drain, counter wrap and async reset.
module tb_demux16_stream;

    localparam int DW = 32;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_sel;
    logic [DW-1:0]     in_data;
    logic [15:0]       out_valid;
    logic [15:0]       out_ready;
    logic [16*DW-1:0]  out_data;
    logic [CW-1:0]     xfer_cnt;

    int n_vec = 0;
    int n_err = 0;

    demux16_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] slot(input int k);
        return out_data[k*DW +: DW];
    endfunction

    // Drive one beat at the falling edge, check in_ready, then sample after the rising edge.
    task automatic beat(input logic [3:0] sel, input logic [DW-1:0] data, input logic exp_rdy);
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        #1 check("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic [15:0] rdy);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
    endtask

    int exp_next [16];
    int rcv [16];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 4'd0;
        in_data   = '0;
        out_ready = '0;
        #2;
        check("rst out_valid", out_valid, 32'h0);
        check("rst xfer_cnt", xfer_cnt, 32'h0);
        check("rst in_ready", in_ready, 32'h0);
        check("rst data zero", out_data == '0, 32'h1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic routing
        beat(4'd5, 32'hA5A5_0005, 1'b1);
        check("t1 out_valid", out_valid, 32'h0020);
        check("t1 slot5", slot(5), 32'hA5A5_0005);
        check("t1 xfer_cnt", xfer_cnt, 32'd1);

        // Backpressure: channel 5 full and stalled
        beat(4'd5, 32'h0000_1111, 1'b0);
        check("t2 xfer_cnt held", xfer_cnt, 32'd1);
        check("t2 slot5 held", slot(5), 32'hA5A5_0005);
        check("t2 out_valid held", out_valid, 32'h0020);
        beat(4'd9, 32'h0000_2222, 1'b1);
        check("t2 out_valid", out_valid, 32'h0220);
        check("t2 slot9", slot(9), 32'h0000_2222);
        check("t2 xfer_cnt", xfer_cnt, 32'd2);

        // Drain and refill in the same cycle, then stream
        beat(4'd3, 32'h33, 1'b1);
        check("t3 out_valid fill", out_valid, 32'h0228);
        out_ready = 16'h0008;
        for (int v = 'h34; v <= 'h3F; v++) begin
            beat(4'd3, v, 1'b1);
            check("t3 valid3", out_valid[3], 32'h1);
            check("t3 slot3", slot(3), v);
        end
        check("t3 xfer_cnt", xfer_cnt, 32'd15);
        idle_cycle(16'h0008);
        check("t3 drained", out_valid, 32'h0220);
        check("t3 slot3 kept", slot(3), 32'h3F);

        // Multi-drain
        reset_pulse();
        beat(4'd0, 32'h10, 1'b1);
        beat(4'd7, 32'h17, 1'b1);
        beat(4'd15, 32'h1F, 1'b1);
        check("t4 out_valid full", out_valid, 32'h8081);
        idle_cycle(16'h8081);
        check("t4 out_valid", out_valid, 32'h0);
        check("t4 xfer_cnt", xfer_cnt, 32'd3);
        check("t4 slot7 held", slot(7), 32'h17);
        idle_cycle(16'h0000);

        // Async reset mid-operation
        beat(4'd1, 32'h11, 1'b1);
        beat(4'd2, 32'h22, 1'b1);
        beat(4'd4, 32'h44, 1'b1);
        idle_cycle(16'h0002);
        check("t6 out_valid pre", out_valid, 32'h0014);
        check("t6 xfer_cnt pre", xfer_cnt, 32'd6);
        @(negedge clk);
        out_ready = '0;
        in_valid  = 1'b1;
        in_sel    = 4'd2;
        in_data   = 32'h5555;
        #2 rst_n = 1'b0;
        #1;
        check("t6 rst out_valid", out_valid, 32'h0);
        check("t6 rst xfer_cnt", xfer_cnt, 32'h0);
        check("t6 rst data zero", out_data == '0, 32'h1);
        check("t6 rst in_ready", in_ready, 32'h0);
        @(posedge clk);
        #1 check("t6 rst held over edge", out_valid, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        beat(4'd4, 32'hBEEF, 1'b1);
        check("t6 out_valid post", out_valid, 32'h0010);
        check("t6 slot4 post", slot(4), 32'hBEEF);
        check("t6 xfer_cnt post", xfer_cnt, 32'd1);

        // Counter wrap with round-robin over all channels
        reset_pulse();
        out_ready = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            exp_next[k] = k;
            rcv[k]      = 0;
        end
        for (int i = 0; i < 65536; i++) begin
            beat(i[3:0], i, 1'b1);
            if (out_valid[i[3:0]] === 1'b1 && slot(i[3:0]) === exp_next[i[3:0]])
                rcv[i[3:0]]++;
            check("t5 slot order", slot(i[3:0]), exp_next[i[3:0]]);
            exp_next[i[3:0]] += 16;
            if (i == 65534) check("t5 cnt FFFF", xfer_cnt, 32'hFFFF);
            if (i == 65535) check("t5 cnt wrap", xfer_cnt, 32'h0000);
        end
        for (int k = 0; k < 16; k++)
            check("t5 per-channel beats", rcv[k], 32'd4096);
        idle_cycle(16'hFFFF);
        check("t5 all drained", out_valid, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
